// File: rtl/ser_tx.sv
`default_nettype none
// ser_tx: parallel-to-serial transmitter feeding the 32-bit deserializer.
// One load cycle plus WIDTH LSB-first data cycles per word; one-word holding buffer.
module ser_tx #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sd,
  output logic             ser_en,
  output logic             ser_load,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic             hold_v;
  logic [CW-1:0]    bitcnt;
  logic [CW-1:0]    bit_next;
  logic             last_b0;

  assign bit_next = bitcnt + CW'(1);
  assign busy     = hold_v | (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      shreg      <= '0;
      hold_v     <= 1'b0;
      bitcnt     <= '0;
      last_b0    <= 1'b0;
      tx_ready   <= 1'b1;
      sd         <= 1'b0;
      ser_en     <= 1'b0;
      ser_load   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      ser_en <= 1'b1;

      // tx_ready mirrors !hold_v, so acceptance and transfer are mutually exclusive.
      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        hold_v   <= 1'b1;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE, LOAD: begin
          frame_done <= 1'b0;
          if (hold_v) begin
            shreg    <= hold;
            hold_v   <= 1'b0;
            tx_ready <= 1'b1;
            last_b0  <= hold[0];
            bitcnt   <= '0;
            sd       <= hold[0];
            ser_load <= 1'b0;
            state    <= SHIFT;
          end else begin
            sd       <= last_b0;
            ser_load <= 1'b1;
            state    <= IDLE;
          end
        end
        SHIFT: begin
          // bitcnt wraps to zero on the last bit, matching the deserializer counter.
          bitcnt <= bit_next;
          if (bitcnt == LAST_BIT) begin
            sd         <= last_b0;
            ser_load   <= 1'b1;
            frame_done <= 1'b1;
            state      <= LOAD;
          end else begin
            sd <= shreg[bit_next];
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ser_tx.sv
`default_nettype none
// tb_ser_tx: directed stimulus with a scoreboard checked against a deserializer model.
module tb_ser_tx;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, sd, ser_en, ser_load, busy, frame_done;

  ser_tx #(.WIDTH(32), .CW(5)) dut (
    .clock(clock), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sd(sd), .ser_en(ser_en), .ser_load(ser_load),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Deserializer model: bit-0 latch follows din while load is high.
  logic [31:0] des_acc = '0;
  logic [31:0] des_dout = '0;
  logic [4:0]  des_cnt = '0;
  always @(posedge clock) begin
    if (ser_en) begin
      if (ser_load) begin
        des_dout   <= {des_acc[31:1], sd};
        des_acc[0] <= sd;
        des_cnt    <= '0;
      end else begin
        des_acc[des_cnt] <= sd;
        des_cnt          <= des_cnt + 5'd1;
      end
    end
  end

  logic [31:0] exp_q[$];
  int          fd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard one cycle after each closing load.
  always @(negedge clock) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h expected no frame", des_dout);
        end else begin
          chk("dout", des_dout, exp_q.pop_front());
        end
      end
      pend <= frame_done;
      if (frame_done) fd_q.push_back(cyc);
      if (dut.hold_v) chk("ready_while_held", {31'b0, tx_ready}, 32'd0);
    end
  end

  // Called at a negedge; t is the cycle whose closing edge accepts the word.
  task automatic send(input logic [31:0] w, output int t);
    int n;
    n = 0;
    t = -1;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end else begin
      t = cyc;
      exp_q.push_back(w);
    end
    @(negedge clock);
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (fd_q.size() < n && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk("frame_count", fd_q.size(), n);
  endtask

  logic [31:0] w;
  logic [31:0] data;
  int          t, t2, n_acc;

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_outputs", {26'b0, tx_ready, ser_load, sd, ser_en, frame_done, busy}, 32'b110000);
    rst_n = 1'b1;
    @(negedge clock);
    chk("ser_en_after_reset", {31'b0, ser_en}, 32'd1);

    // Single word: bit order, frame timing, long idle hold.
    w = 32'hA5C3_0F81;
    fd_q.delete();
    send(w, t);
    tx_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("sd_bit%0d", i), {30'b0, ser_load, sd}, {30'b0, 1'b0, w[i]});
      @(negedge clock);
    end
    chk("fd_pulse", {31'b0, frame_done}, 32'd1);
    chk("fd_cycle", cyc, t + 34);
    repeat (50) begin
      @(negedge clock);
      chk("dout_hold", des_dout, w);
    end
    chk("busy_idle", {31'b0, busy}, 32'd0);

    // Back-to-back with valid held high.
    fd_q.delete();
    send(32'hFFFF_FFFF, t);
    send(32'h0000_0000, t);
    send(32'h8000_0001, t);
    tx_valid = 1'b0;
    wait_frames(3);
    if (fd_q.size() >= 3) begin
      chk("b2b_gap1", fd_q[1] - fd_q[0], 32'd33);
      chk("b2b_gap2", fd_q[2] - fd_q[1], 32'd33);
    end
    repeat (5) @(negedge clock);

    // Idle bit-0 stability.
    w = 32'h0000_0001;
    fd_q.delete();
    send(w, t);
    tx_valid = 1'b0;
    wait_frames(1);
    repeat (40) begin
      @(negedge clock);
      chk("idle_sd", {30'b0, ser_load, sd}, 32'd3);
      chk("idle_dout", des_dout, w);
    end

    // Reset in the bit-17 cycle, then a clean word.
    send(32'hDEAD_BEEF, t);
    tx_valid = 1'b0;
    repeat (18) @(negedge clock);
    chk("bit17_cycle", cyc, t + 19);
    #2 rst_n = 1'b0;
    #1 chk("midframe_reset_outputs", {26'b0, tx_ready, ser_load, sd, ser_en, frame_done, busy}, 32'b110000);
    exp_q.delete();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("ser_en_after_rerelease", {31'b0, ser_en}, 32'd1);
    fd_q.delete();
    w = 32'h1234_5678;
    send(w, t);
    tx_valid = 1'b0;
    wait_frames(1);
    if (fd_q.size() >= 1) chk("post_reset_fd_cycle", fd_q[0], t + 34);
    repeat (3) @(negedge clock);
    chk("post_reset_dout", des_dout, w);

    // Backpressure: valid held 100 cycles, data advances only on acceptance.
    fd_q.delete();
    data  = 32'h0000_0100;
    n_acc = 0;
    tx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tx_data = data;
      if (tx_ready) begin
        exp_q.push_back(data);
        n_acc++;
        data = data + 32'd1;
      end
      @(negedge clock);
    end
    tx_valid = 1'b0;
    chk("bp_accepted", n_acc, 32'd4);
    wait_frames(n_acc);
    repeat (3) @(negedge clock);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Hand-off: second word offered in the bit-31 cycle of the first.
    fd_q.delete();
    send(32'h0000_0002, t);
    tx_valid = 1'b0;
    repeat (32) @(negedge clock);
    send(32'h0000_0003, t2);
    chk("handoff_accept_cycle", t2, t + 33);
    chk("handoff_load", {30'b0, ser_load, frame_done}, 32'd3);
    tx_valid = 1'b0;
    @(negedge clock);
    chk("handoff_bit0", {30'b0, ser_load, sd}, 32'd1);
    wait_frames(2);
    repeat (3) @(negedge clock);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
